count_seq_checker: RTL and testbench
====================================

Name: count_seq_checker

Overview:
Receive-side companion to the free-running counter_mux output. It samples a WIDTH-bit count stream and locks onto it after a run of correct +1 increments. It then flags every skipped, stalled or out-of-order value. It sits beside any counter instance as an in-design sequence monitor and drives a sticky error counter for status readback.

Parameters:
WIDTH, 4, width of the observed count stream.
LOCK_CNT, 3, consecutive correct increments required to declare lock (legal range 1 to 15).
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous active-low reset: asserted (0) clears all state immediately; released synchronously to clk.
valid  input  1  q_in is sampled only on edges where valid=1.
q_in  input  WIDTH  observed count value.
clear  input  1  synchronous clear of err_count.
locked  output  1  registered; 1 while the stream is tracked.
err_pulse  output  1  registered one-cycle pulse per sequence error detected while locked.
err_count  output  ERR_CNT_W  saturating count of errors since reset/clear.
expected  output  WIDTH  next value predicted: prev+1 mod 2^WIDTH; 0 in IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, prev=0, match=0, locked=0, err_pulse=0, err_count=0, expected=0.
- Internal state: prev (WIDTH bits) holds the last sampled value; match is a 4-bit run counter.
- Correct sample: q_in == (prev+1) mod 2^WIDTH. Wrap from all-ones to 0 is correct. A repeated value (stall) is an error.
- All decisions occur on a clk edge with valid=1. Edges with valid=0 change nothing except clear; the state, lock and prev all hold.
- Outputs are registered. A sample taken at edge N is reflected in outputs after edge N.
- FSM IDLE:
  - on valid: prev<=q_in; match<=0; go to ACQUIRE.
- FSM ACQUIRE:
  - on valid with correct sample: match<=match+1. If match+1 == LOCK_CNT, go to LOCKED and set locked<=1.
  - on valid with incorrect sample: match<=0; stay in ACQUIRE; no err_pulse and no err_count change, because errors are counted only while locked.
  - prev<=q_in on every valid sample.
- FSM LOCKED:
  - on valid with correct sample: stay in LOCKED.
  - on valid with incorrect sample: err_pulse<=1 for exactly one cycle; err_count increments; locked<=0; match<=0; go to ACQUIRE.
  - prev<=q_in on every valid sample, so reacquisition starts from the erroneous value.
- err_pulse defaults to 0 on every edge unless set by the rule above. Back-to-back errors are impossible, since the second sample is evaluated in ACQUIRE.
- err_count saturates at 2^ERR_CNT_W-1 and never wraps.
- clear=1 sets err_count<=0. If an error and clear occur on the same edge, err_count<=1: clear is applied first, then the increment. clear does not affect the FSM, locked or err_pulse.
- expected = prev+1 mod 2^WIDTH in ACQUIRE and LOCKED, 0 in IDLE.
- Reset asserted mid-operation (e.g. while LOCKED): all outputs return to reset values without waiting for a clock edge; the first valid sample after release restarts from IDLE.

Test Plan:
1. Release reset, drive valid=1 with q_in=0,1,2,3,4 on consecutive edges -> locked=1 after the edge sampling 3 (LOCK_CNT=3); err_count=0; expected=4 after that edge.
2. Locked stream continues 13,14,15,0,1 -> no err_pulse, locked stays 1 across the 15->0 wrap.
3. Locked; drive 5,6,8,9,10,11 -> err_pulse=1 for one cycle after the edge sampling 8; err_count=1; locked=0; locked=1 again after the edge sampling 11.
4. Locked at 6; drive valid=0 for 5 cycles with q_in=garbage, then valid=1 with q_in=7 -> locked stays 1 throughout, no error. Repeat with a stalled value 7,7 -> one error.
5. ERR_CNT_W=8; induce 300 errors (lock, skip, relock each time) -> err_count stops at 255. Assert clear on the same edge as the next error -> err_count=1.
6. Locked mid-stream; pulse reset=0 between clock edges -> locked, err_count and expected read 0 before the next edge. After release, q_in=9,10,11,12 -> locked=1 again.

Source files
------------

// File: rtl/count_seq_checker.sv
// Sequence monitor for a free-running count stream: locks after LOCK_CNT correct +1 steps, then flags skips/stalls.
// All outputs reflect the sample taken at edge N right after edge N; there is no backpressure (valid-only input).
module count_seq_checker #(
    parameter int WIDTH     = 4,
    parameter int LOCK_CNT  = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     q_in,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]           LOCK_THR = 4'(LOCK_CNT);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_prev;
    logic [3:0]           r_match, w_match_nxt;
    logic                 r_err_pulse;
    logic [ERR_CNT_W-1:0] r_err_count, w_cnt_base, w_cnt_nxt;
    logic [WIDTH-1:0]     w_prev_inc;
    logic                 w_correct, w_err;

    assign w_prev_inc = r_prev + 1'b1;
    assign w_correct  = (q_in == w_prev_inc);
    assign w_err      = valid && (r_state == S_LOCKED) && !w_correct;

    // Clear wins over the held count, but a same-edge error still lands on top of it.
    assign w_cnt_base = clear ? '0 : r_err_count;
    assign w_cnt_nxt  = (w_err && (w_cnt_base != ERR_MAX)) ? w_cnt_base + 1'b1 : w_cnt_base;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_prev  <= '0;
            r_match <= '0;
        end else if (valid) begin
            r_state <= w_state_nxt;
            r_prev  <= q_in;
            r_match <= w_match_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_ACQUIRE;
                w_match_nxt = '0;
            end
            S_ACQUIRE: begin
                if (w_correct) begin
                    w_match_nxt = r_match + 4'd1;
                    if ((r_match + 4'd1) == LOCK_THR) begin
                        w_state_nxt = S_LOCKED;
                    end
                end else begin
                    w_match_nxt = '0;
                end
            end
            S_LOCKED: begin
                if (!w_correct) begin
                    w_state_nxt = S_ACQUIRE;
                    w_match_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_match_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_err;
            r_err_count <= w_cnt_nxt;
        end
    end

    always_comb begin
        locked    = (r_state == S_LOCKED);
        err_pulse = r_err_pulse;
        err_count = r_err_count;
        expected  = (r_state == S_IDLE) ? '0 : w_prev_inc;
    end
endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: a reference model pushes expected outputs per driven edge; each test pops and compares.
module tb_count_seq_checker;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic       clear = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [3:0] expected;

    int n_pass = 0;
    int n_total = 0;

    logic [13:0] sb[$];

    // Reference model state
    int m_state = 0;
    int m_prev = 0;
    int m_match = 0;
    int m_pulse = 0;
    int m_cnt = 0;

    count_seq_checker #(.WIDTH(4), .LOCK_CNT(3), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .valid(valid), .q_in(q_in), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_match = 0; m_pulse = 0; m_cnt = 0;
        sb.delete();
    endtask

    // Drive one edge, advance the model, push its expected outputs; returns at posedge+1.
    task automatic drive(input logic v, input logic [3:0] q, input logic c);
        bit ok;
        int exp_v;
        valid = v; q_in = q; clear = c;
        @(posedge clk);
        m_pulse = 0;
        if (c) m_cnt = 0;
        if (v) begin
            ok = (int'(q) == ((m_prev + 1) % 16));
            if (m_state == 0) begin
                m_state = 1; m_match = 0;
            end else if (m_state == 1) begin
                if (ok) begin
                    m_match = m_match + 1;
                    if (m_match == 3) m_state = 2;
                end else begin
                    m_match = 0;
                end
            end else if (!ok) begin
                m_pulse = 1;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                m_state = 1; m_match = 0;
            end
            m_prev = int'(q);
        end
        exp_v = (m_state == 0) ? 0 : ((m_prev + 1) % 16);
        sb.push_back({(m_state == 2), (m_pulse == 1), 8'(m_cnt), 4'(exp_v)});
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_total++;
        if ({locked, err_pulse, err_count, expected} !== 14'h0)
            $display("FAIL reset_state: got %h want 0", {locked, err_pulse, err_count, expected});
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_acquire();
        logic [13:0] e;
        logic lk_want [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            e = sb.pop_front();
            n_total++;
            if ({locked, err_pulse, err_count, expected} !== e)
                $display("FAIL acquire_sb[%0d]: got %h want %h", i, {locked, err_pulse, err_count, expected}, e);
            else n_pass++;
            n_total++;
            if (locked !== lk_want[i]) $display("FAIL acquire_locked[%0d]: got %b want %b", i, locked, lk_want[i]);
            else n_pass++;
            if (i == 3) begin
                n_total++;
                if (expected !== 4'd4 || err_count !== 8'd0)
                    $display("FAIL acquire_expected: got exp=%0d cnt=%0d want exp=4 cnt=0", expected, err_count);
                else n_pass++;
            end
        end
    endtask

    task automatic test_skip_relock();
        logic [13:0] e;
        logic [3:0] seq [6] = '{4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, seq[i], 1'b0);
            e = sb.pop_front();
            n_total++;
            if ({locked, err_pulse, err_count, expected} !== e)
                $display("FAIL skip_sb[%0d]: got %h want %h", i, {locked, err_pulse, err_count, expected}, e);
            else n_pass++;
            if (i == 2) begin
                n_total++;
                if ({locked, err_pulse, err_count} !== {1'b0, 1'b1, 8'd1})
                    $display("FAIL skip_error: got lk=%b p=%b cnt=%0d want lk=0 p=1 cnt=1", locked, err_pulse, err_count);
                else n_pass++;
            end
            if (i == 3) begin
                n_total++;
                if (err_pulse !== 1'b0) $display("FAIL skip_pulse_width: got %b want 0", err_pulse);
                else n_pass++;
            end
        end
        n_total++;
        if (locked !== 1'b1) $display("FAIL skip_relock: got %b want 1", locked);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [13:0] e;
        logic [3:0] seq [6] = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, seq[i], 1'b0);
            e = sb.pop_front();
            n_total++;
            if ({locked, err_pulse, err_count, expected} !== e)
                $display("FAIL wrap_sb[%0d]: got %h want %h", i, {locked, err_pulse, err_count, expected}, e);
            else n_pass++;
            n_total++;
            if (locked !== 1'b1 || err_pulse !== 1'b0)
                $display("FAIL wrap_locked[%0d]: got lk=%b p=%b want lk=1 p=0", i, locked, err_pulse);
            else n_pass++;
        end
    endtask

    task automatic test_valid_gap_and_stall();
        logic [13:0] e;
        for (int i = 2; i <= 6; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            e = sb.pop_front();
            n_total++;
            if ({locked, err_pulse, err_count, expected} !== e)
                $display("FAIL gap_prelock[%0d]: got %h want %h", i, {locked, err_pulse, err_count, expected}, e);
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'($urandom_range(0, 15)), 1'b0);
            e = sb.pop_front();
            n_total++;
            if ({locked, err_pulse, err_count, expected} !== e || locked !== 1'b1 || expected !== 4'd7)
                $display("FAIL gap_hold[%0d]: got %h want %h", i, {locked, err_pulse, err_count, expected}, e);
            else n_pass++;
        end
        drive(1'b1, 4'd7, 1'b0);
        e = sb.pop_front();
        n_total++;
        if ({locked, err_pulse, err_count, expected} !== e || locked !== 1'b1 || err_pulse !== 1'b0)
            $display("FAIL gap_resume: got %h want %h", {locked, err_pulse, err_count, expected}, e);
        else n_pass++;
        drive(1'b1, 4'd7, 1'b0);
        e = sb.pop_front();
        n_total++;
        if ({locked, err_pulse, err_count, expected} !== e || err_pulse !== 1'b1 || err_count !== 8'd2)
            $display("FAIL stall_error: got %h want %h", {locked, err_pulse, err_count, expected}, e);
        else n_pass++;
    endtask

    task automatic test_saturate_and_clear();
        logic [13:0] e;
        logic [3:0] v;
        int bad;
        bad = 0;
        for (int i = 8; i <= 10; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            e = sb.pop_front();
            if ({locked, err_pulse, err_count, expected} !== e) bad++;
        end
        v = 4'd10;
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, v + 4'd2, 1'b0);
            e = sb.pop_front();
            if ({locked, err_pulse, err_count, expected} !== e) bad++;
            for (int j = 3; j <= 5; j++) begin
                drive(1'b1, v + 4'(j), 1'b0);
                e = sb.pop_front();
                if ({locked, err_pulse, err_count, expected} !== e) bad++;
            end
            v = v + 4'd5;
        end
        n_total++;
        if (bad != 0) $display("FAIL saturate_sb: got %0d mismatching cycles want 0", bad);
        else n_pass++;
        n_total++;
        if (err_count !== 8'd255 || locked !== 1'b1)
            $display("FAIL saturate_cap: got cnt=%0d lk=%b want cnt=255 lk=1", err_count, locked);
        else n_pass++;
        drive(1'b1, v + 4'd2, 1'b1);
        e = sb.pop_front();
        n_total++;
        if ({locked, err_pulse, err_count, expected} !== e || err_count !== 8'd1 || err_pulse !== 1'b1)
            $display("FAIL clear_with_error: got %h want %h", {locked, err_pulse, err_count, expected}, e);
        else n_pass++;
        drive(1'b0, 4'd0, 1'b1);
        e = sb.pop_front();
        n_total++;
        if ({locked, err_pulse, err_count, expected} !== e || err_count !== 8'd0)
            $display("FAIL clear_only: got %h want %h", {locked, err_pulse, err_count, expected}, e);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [13:0] e;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            e = sb.pop_front();
        end
        n_total++;
        if (locked !== 1'b1 || expected !== 4'd5) $display("FAIL midreset_pre: got lk=%b exp=%0d want lk=1 exp=5", locked, expected);
        else n_pass++;
        reset = 1'b0;
        #2;
        n_total++;
        if ({locked, err_pulse, err_count, expected} !== 14'h0)
            $display("FAIL midreset_async: got %h want 0", {locked, err_pulse, err_count, expected});
        else n_pass++;
        model_reset();
        reset = 1'b1;
        for (int i = 9; i <= 12; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            e = sb.pop_front();
            n_total++;
            if ({locked, err_pulse, err_count, expected} !== e)
                $display("FAIL midreset_sb[%0d]: got %h want %h", i, {locked, err_pulse, err_count, expected}, e);
            else n_pass++;
        end
        n_total++;
        if (locked !== 1'b1 || expected !== 4'd13) $display("FAIL midreset_relock: got lk=%b exp=%0d want lk=1 exp=13", locked, expected);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_skip_relock();
        test_wrap();
        test_valid_gap_and_stall();
        test_saturate_and_clear();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
